ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Consumes raw PS/2 scan-code bytes from the keyboard receiver FIFO (data/ready/nextdata_n handshake).
- Assembles multi-byte sequences (E0 extended prefix, F0 break prefix) into single key events.
- Each event carries make/break, ASCII translation, held-key tracking and a press counter.
- Sits directly downstream of the receiver and feeds the display/console logic.

Parameters:
- CNT_W, 8, width of press_count; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ps2_byte  in  8  byte at receiver FIFO head
- ps2_ready  in  1  receiver FIFO non-empty
- ps2_overflow  in  1  receiver FIFO overflow flag
- nextdata_n  out  1  active-low pop strobe to receiver
- key_valid  out  1  one-cycle event pulse
- key_code  out  8  final scan code of event
- key_ext  out  1  event was E0-prefixed
- key_release  out  1  1 = break, 0 = make
- key_ascii  out  8  ASCII of key_code, 0x00 if unmapped or extended
- key_held  out  1  a key is currently held
- press_count  out  CNT_W  counted make events
- ovf_seen  out  1  sticky: receiver overflow observed

Behaviour:
- Reset (clrn=0, async): nextdata_n=1; key_valid=0; key_code=0; key_ext=0; key_release=0; key_ascii=0; key_held=0; press_count=0; ovf_seen=0; FSM=IDLE.
- Reset mid-sequence discards the partial prefix; no event is produced.
- Pop handshake:
  - Cycle T: fetch stage idle and ps2_ready=1 → capture ps2_byte.
  - T+1: nextdata_n=0 (registered, exactly one cycle).
  - T+2: wait cycle, ps2_ready ignored.
  - T+3: earliest next capture.
  - Never pop while ps2_ready=0.
- Prefix FSM, advanced on each captured byte b:
  - IDLE: E0→EXT; F0→BRK; else emit make(b, ext=0), stay IDLE.
  - EXT: F0→EXTBRK; E0→EXT; else emit make(b, ext=1), go IDLE.
  - BRK: F0→BRK; E0→EXT (resync); else emit break(b, ext=0), go IDLE.
  - EXTBRK: E0 or F0→EXTBRK; else emit break(b, ext=1), go IDLE.
- Event timing: key_valid=1 at T+1 for final byte captured at T. key_code/key_ext/key_release/key_ascii update in the same cycle and hold until the next event.
- ASCII map (ext=0 only):
  - Letters uppercase: 1C→41 'A' … 1A→5A 'Z'.
  - Top-row digits: 45→30 '0', 16→31 '1' … 46→39 '9'.
  - 29→20 space; 5A→0D enter; 66→08 backspace.
  - All other codes → 00.
- Held tracking: internal held_code[7:0] and held_ext.
  - Make: held_code/held_ext ← event; key_held=1.
  - Break whose (code, ext) matches held: key_held=0.
  - Non-matching break: event still emitted; key_held unchanged.
- press_count increments on each emitted make event (subject to filter below). Wraps 2^CNT_W−1→0.
- Overflow: ps2_overflow=1 sampled → ovf_seen=1 (cleared only by reset) and FSM forced to IDLE. The in-flight pop still completes.
- Simultaneous overflow and final byte: the overflow takes priority and no event is emitted.

Optional Feature:
- REPEAT_FILTER_EN defined: a make whose (code, ext) equals the held key while key_held=1 is a typematic repeat. For such a byte: no key_valid, no count, outputs unchanged; the byte is still popped.
- Not defined: every make emits an event and increments press_count.

Test Plan:
- Bytes 1C, F0, 1C with ready asserted: two key_valid pulses. First: code 1C, ascii 41, release=0, count=1, key_held=1. Second: release=1, key_held=0. nextdata_n low exactly 3 single cycles, each ≥3 cycles apart.
- Bytes E0, 75, E0, F0, 75: one make event (code 75, ext=1, ascii 00) and one break event (ext=1). No events on prefix bytes.
- Bytes 16, 16, 16 (held repeat), then F0, 16:
  - With REPEAT_FILTER_EN: one make pulse, count=1.
  - Without it: three make pulses, count=3.
  - Break ends with key_held=0.
- Preload 255 makes (alternating 1C / F0 1C), then one more make: press_count 0xFF→0x00.
- Pulse ps2_overflow during EXTBRK after E0, F0: ovf_seen=1 and FSM returns to IDLE. Next byte 29 → make event, ascii 20, ext=0.
- Assert clrn=0 after F0 received, release, send 1C: make event (release=0), all outputs reset beforehand.

Source files
------------

// File: rtl/ps2_scancode_decoder_if.sv
// Handshake and event bundle between the PS/2 receiver FIFO, the scan-code
// decoder and its downstream consumer.
interface ps2_scancode_decoder_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       ps2_byte;
  logic             ps2_ready;
  logic             ps2_overflow;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_release;
  logic [7:0]       key_ascii;
  logic             key_held;
  logic [CNT_W-1:0] press_count;
  logic             ovf_seen;

  modport master (
    output ps2_byte, ps2_ready, ps2_overflow,
    input  nextdata_n, key_valid, key_code, key_ext, key_release,
           key_ascii, key_held, press_count, ovf_seen
  );

  modport slave (
    input  ps2_byte, ps2_ready, ps2_overflow,
    output nextdata_n, key_valid, key_code, key_ext, key_release,
           key_ascii, key_held, press_count, ovf_seen
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: pops receiver bytes, folds E0/F0 prefixes into key events.
// Optional macro REPEAT_FILTER_EN suppresses typematic repeats of the held key.
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  ps2_scancode_decoder_if.slave  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXT    = 2'd1;
  localparam logic [1:0] S_BRK    = 2'd2;
  localparam logic [1:0] S_EXTBRK = 2'd3;
  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_BRK    = 8'hF0;

  logic [1:0]       r_state;
  logic [1:0]       r_wait;
  logic             r_nextdata_n;
  logic             r_key_valid;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic             r_key_release;
  logic [7:0]       r_key_ascii;
  logic             r_key_held;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic [CNT_W-1:0] r_press_count;
  logic             r_ovf_seen;

  logic [1:0]       w_state_nxt;
  logic             w_emit;
  logic             w_ext;
  logic             w_rel;
  logic             w_capture;
  logic             w_repeat;
  logic             w_fire;
  logic             w_held_match;

  function automatic logic [7:0] f_ascii(input logic [7:0] code);
    case (code)
      8'h1C: f_ascii = 8'h41;  8'h32: f_ascii = 8'h42;  8'h21: f_ascii = 8'h43;
      8'h23: f_ascii = 8'h44;  8'h24: f_ascii = 8'h45;  8'h2B: f_ascii = 8'h46;
      8'h34: f_ascii = 8'h47;  8'h33: f_ascii = 8'h48;  8'h43: f_ascii = 8'h49;
      8'h3B: f_ascii = 8'h4A;  8'h42: f_ascii = 8'h4B;  8'h4B: f_ascii = 8'h4C;
      8'h3A: f_ascii = 8'h4D;  8'h31: f_ascii = 8'h4E;  8'h44: f_ascii = 8'h4F;
      8'h4D: f_ascii = 8'h50;  8'h15: f_ascii = 8'h51;  8'h2D: f_ascii = 8'h52;
      8'h1B: f_ascii = 8'h53;  8'h2C: f_ascii = 8'h54;  8'h3C: f_ascii = 8'h55;
      8'h2A: f_ascii = 8'h56;  8'h1D: f_ascii = 8'h57;  8'h22: f_ascii = 8'h58;
      8'h35: f_ascii = 8'h59;  8'h1A: f_ascii = 8'h5A;
      8'h45: f_ascii = 8'h30;  8'h16: f_ascii = 8'h31;  8'h1E: f_ascii = 8'h32;
      8'h26: f_ascii = 8'h33;  8'h25: f_ascii = 8'h34;  8'h2E: f_ascii = 8'h35;
      8'h36: f_ascii = 8'h36;  8'h3D: f_ascii = 8'h37;  8'h3E: f_ascii = 8'h38;
      8'h46: f_ascii = 8'h39;
      8'h29: f_ascii = 8'h20;  8'h5A: f_ascii = 8'h0D;  8'h66: f_ascii = 8'h08;
      default: f_ascii = 8'h00;
    endcase
  endfunction

  // Capture, then one pop cycle and one wait cycle before the next capture.
  assign w_capture = (r_wait == 2'd0) && bus.ps2_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_rel       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ps2_byte == B_EXT)      w_state_nxt = S_EXT;
        else if (bus.ps2_byte == B_BRK) w_state_nxt = S_BRK;
        else                            w_emit = 1'b1;
      end
      S_EXT: begin
        if (bus.ps2_byte == B_BRK)      w_state_nxt = S_EXTBRK;
        else if (bus.ps2_byte != B_EXT) begin
          w_emit = 1'b1; w_ext = 1'b1; w_state_nxt = S_IDLE;
        end
      end
      S_BRK: begin
        if (bus.ps2_byte == B_EXT)      w_state_nxt = S_EXT;
        else if (bus.ps2_byte != B_BRK) begin
          w_emit = 1'b1; w_rel = 1'b1; w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (bus.ps2_byte != B_EXT && bus.ps2_byte != B_BRK) begin
          w_emit = 1'b1; w_ext = 1'b1; w_rel = 1'b1; w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  assign w_held_match = (bus.ps2_byte == r_held_code) && (w_ext == r_held_ext);
`ifdef REPEAT_FILTER_EN
  assign w_repeat = !w_rel && r_key_held && w_held_match;
`else
  assign w_repeat = 1'b0;
`endif
  // Overflow wins over a final byte captured in the same cycle.
  assign w_fire = w_capture && !bus.ps2_overflow && w_emit && !w_repeat;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state       <= S_IDLE;
      r_wait        <= 2'd0;
      r_nextdata_n  <= 1'b1;
      r_key_valid   <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_release <= 1'b0;
      r_key_ascii   <= 8'h00;
      r_key_held    <= 1'b0;
      r_held_code   <= 8'h00;
      r_held_ext    <= 1'b0;
      r_press_count <= '0;
      r_ovf_seen    <= 1'b0;
    end else begin
      r_nextdata_n <= !w_capture;
      if (w_capture)           r_wait <= 2'd2;
      else if (r_wait != 2'd0) r_wait <= r_wait - 2'd1;

      if (bus.ps2_overflow) begin
        r_ovf_seen <= 1'b1;
        r_state    <= S_IDLE;
      end else if (w_capture) begin
        r_state <= w_state_nxt;
      end

      r_key_valid <= w_fire;
      if (w_fire) begin
        r_key_code    <= bus.ps2_byte;
        r_key_ext     <= w_ext;
        r_key_release <= w_rel;
        r_key_ascii   <= w_ext ? 8'h00 : f_ascii(bus.ps2_byte);
        if (!w_rel) begin
          r_held_code   <= bus.ps2_byte;
          r_held_ext    <= w_ext;
          r_key_held    <= 1'b1;
          r_press_count <= r_press_count + CNT_W'(1);
        end else if (w_held_match) begin
          r_key_held <= 1'b0;
        end
      end
    end
  end

  assign bus.nextdata_n  = r_nextdata_n;
  assign bus.key_valid   = r_key_valid;
  assign bus.key_code    = r_key_code;
  assign bus.key_ext     = r_key_ext;
  assign bus.key_release = r_key_release;
  assign bus.key_ascii   = r_key_ascii;
  assign bus.key_held    = r_key_held;
  assign bus.press_count = r_press_count;
  assign bus.ovf_seen    = r_ovf_seen;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: byte FIFO emulation, sequence-level reference
// model of the prefix/event rules, directed plus randomized byte streams.
module tb_ps2_scancode_decoder;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  ps2_scancode_decoder_if #(.CNT_W(8)) bus ();
  ps2_scancode_decoder #(.CNT_W(8)) dut (.clk(clk), .clrn(clrn), .bus(bus.slave));

  always #5 clk = ~clk;

  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
    8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Receiver FIFO: written by the stimulus, popped on nextdata_n.
  logic [7:0]  fifo_mem [0:4095];
  int          wr_idx = 0;
  int          rd_idx = 0;
  assign bus.ps2_ready = (rd_idx != wr_idx);
  assign bus.ps2_byte  = fifo_mem[rd_idx[11:0]];

  logic [26:0] obs_mem [0:1023];
  int          obs_wr = 0;
  int          cyc = 0;
  int          last_pop = -100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (clrn && !bus.nextdata_n) begin
      check("pop_spacing", 32'(cyc - last_pop >= 3), 32'd1);
      check("pop_nonempty", 32'(rd_idx != wr_idx), 32'd1);
      last_pop = cyc;
      if (rd_idx != wr_idx) rd_idx++;
    end
    if (bus.key_valid) begin
      obs_mem[obs_wr[9:0]] = {bus.press_count, bus.key_held, bus.key_release,
                              bus.key_ext, bus.key_ascii, bus.key_code};
      obs_wr++;
    end
  end

  // Reference model state
  logic [7:0]  run_q [$];
  logic [26:0] exp_q [$];
  logic [7:0]  m_held_code = 8'h00;
  logic        m_held_ext = 1'b0;
  logic        m_held = 1'b0;
  logic [7:0]  m_count = 8'h00;
  logic        m_ovf = 1'b0;
  int          obs_rd = 0;

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic e);
    model_ascii = 8'h00;
    if (!e) begin
      for (int i = 0; i < 26; i++) if (LETTERS[i] == c) model_ascii = 8'(8'h41 + i);
      for (int i = 0; i < 10; i++) if (DIGITS[i] == c) model_ascii = 8'(8'h30 + i);
      if (c == 8'h29) model_ascii = 8'h20;
      if (c == 8'h5A) model_ascii = 8'h0D;
      if (c == 8'h66) model_ascii = 8'h08;
    end
  endfunction

  // A key event is a run of E0/F0 prefixes ended by any other byte. It is
  // extended if the run holds an E0, and a break if an F0 follows the first
  // E0 (or, with no E0, if any F0 is present).
  task automatic model_byte(input logic [7:0] b);
    int   first_e0;
    logic ext, rel, rpt;
    if (b == 8'hE0 || b == 8'hF0) begin
      run_q.push_back(b);
      return;
    end
    first_e0 = -1;
    foreach (run_q[i]) if (run_q[i] == 8'hE0 && first_e0 < 0) first_e0 = i;
    ext = (first_e0 >= 0);
    rel = 1'b0;
    foreach (run_q[i]) if (run_q[i] == 8'hF0 && i > first_e0) rel = 1'b1;
    run_q.delete();
    rpt = 1'b0;
`ifdef REPEAT_FILTER_EN
    rpt = !rel && m_held && (b == m_held_code) && (ext == m_held_ext);
`endif
    if (rpt) return;
    if (!rel) begin
      m_held_code = b; m_held_ext = ext; m_held = 1'b1; m_count++;
    end else if (b == m_held_code && ext == m_held_ext) begin
      m_held = 1'b0;
    end
    exp_q.push_back({m_count, m_held, rel, ext, model_ascii(b, ext), b});
  endtask

  task automatic push_raw(input logic [7:0] b);
    fifo_mem[wr_idx[11:0]] = b;
    wr_idx++;
  endtask

  task automatic push(input logic [7:0] b);
    push_raw(b);
    model_byte(b);
  endtask

  task automatic pulse_ovf();
    @(posedge clk); #1;
    bus.ps2_overflow = 1'b1;
    @(posedge clk); #1;
    bus.ps2_overflow = 1'b0;
    run_q.delete();
    m_ovf = 1'b1;
  endtask

  task automatic drain_check(input string tag);
    int guard = 0;
    while (rd_idx != wr_idx && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    check({tag, "_drain"}, 32'(rd_idx != wr_idx), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_evcnt"}, 32'(obs_wr - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_rd < obs_wr) begin
      check({tag, "_event"}, 32'(obs_mem[obs_rd[9:0]]), 32'(exp_q.pop_front()));
      obs_rd++;
    end
    exp_q.delete();
    obs_rd = obs_wr;
    check({tag, "_held"}, 32'(bus.key_held), 32'(m_held));
    check({tag, "_count"}, 32'(bus.press_count), 32'(m_count));
    check({tag, "_ovf"}, 32'(bus.ovf_seen), 32'(m_ovf));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    clrn = 1'b0;
    #1;
    check({tag, "_outs"}, 32'({bus.nextdata_n, bus.key_valid, bus.key_code, bus.key_ext,
          bus.key_release, bus.key_ascii, bus.key_held, bus.press_count, bus.ovf_seen}),
          32'h2000_0000);
    run_q.delete();
    exp_q.delete();
    m_held_code = 8'h00; m_held_ext = 1'b0; m_held = 1'b0; m_count = 8'h00; m_ovf = 1'b0;
    @(posedge clk); #2;
    clrn = 1'b1;
    obs_rd = obs_wr;
  endtask

  initial begin
    bus.ps2_overflow = 1'b0;
    do_reset("rst0");

    // Make then break of 'A'
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain_check("t1");
    check("t1_code", 32'(bus.key_code), 32'h1C);
    check("t1_ascii", 32'(bus.key_ascii), 32'h41);
    check("t1_release", 32'(bus.key_release), 32'd1);
    check("t1_count", 32'(bus.press_count), 32'd1);

    // Extended make and extended break
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain_check("t2");
    check("t2_ext", 32'(bus.key_ext), 32'd1);

    // Held repeat then break
    push(8'h16); push(8'h16); push(8'h16); push(8'hF0); push(8'h16);
    drain_check("t3");
`ifdef REPEAT_FILTER_EN
    check("t3_count", 32'(bus.press_count), 32'd3);
`else
    check("t3_count", 32'(bus.press_count), 32'd5);
`endif

    // Overflow while in the extended-break prefix
    push(8'hE0); push(8'hF0);
    drain_check("t4a");
    pulse_ovf();
    check("t4_ovf", 32'(bus.ovf_seen), 32'd1);
    push(8'h29);
    drain_check("t4b");
    check("t4_ascii", 32'(bus.key_ascii), 32'h20);
    check("t4_ext", 32'(bus.key_ext), 32'd0);

    // Overflow coinciding with a final byte: byte consumed, no event
    push(8'hE0);
    drain_check("t5a");
    @(posedge clk); #1;
    push_raw(8'h6B);
    bus.ps2_overflow = 1'b1;
    @(posedge clk); #1;
    bus.ps2_overflow = 1'b0;
    run_q.delete();
    drain_check("t5b");
    push(8'h6B);
    drain_check("t5c");

    // Reset mid-sequence drops the pending break prefix
    push(8'hF0);
    drain_check("t6a");
    do_reset("rst1");
    push(8'h1C);
    drain_check("t6b");
    check("t6_release", 32'(bus.key_release), 32'd0);

    // press_count wrap
    do_reset("rst2");
    for (int i = 0; i < 255; i++) begin
      push(8'h1C); push(8'hF0); push(8'h1C);
    end
    drain_check("t7a");
    check("t7_full", 32'(bus.press_count), 32'hFF);
    push(8'h1C);
    drain_check("t7b");
    check("t7_wrap", 32'(bus.press_count), 32'h00);

    // Randomized byte stream with random arrival gaps
    for (int i = 0; i < 200; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 11))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'h1C;
        5:       b = 8'h16;
        6:       b = 8'h75;
        7:       b = 8'h29;
        8:       b = 8'h5A;
        9:       b = 8'h45;
        10:      b = 8'h66;
        default: b = 8'($urandom_range(0, 255));
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      push(b);
    end
    drain_check("rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
